// File: rtl/mem_fill_arbiter_if.sv
// Cache/memory-side bundle for mem_fill_arbiter: miss and store requests, memory port, fill outputs.
// master = arbiter side, slave = caches plus main memory.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              icache_miss;
  logic [ADDR_W-1:0] icache_miss_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_miss_addr;
  logic              dcache_wr_req;
  logic [ADDR_W-1:0] dcache_wr_addr;
  logic [DATA_W-1:0] dcache_wr_data;
  logic              dcache_wr_ack;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_word_idx;
  logic              icache_fill_we;
  logic              dcache_fill_we;
  logic              icache_tag_we;
  logic              dcache_tag_we;
  logic              icache_busy;
  logic              dcache_busy;

  modport master (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_rdata, mem_data_valid,
    output dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word_idx,
           icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we, icache_busy, dcache_busy
  );

  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_rdata, mem_data_valid,
    input  dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word_idx,
           icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we, icache_busy, dcache_busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shared memory-port sequencer for I/D caches: write-through stores and 8-word block fills.
// Define ARB_ROUND_ROBIN_EN to alternate I/D miss grants; default is fixed D-over-I priority.
module mem_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_fill_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = IDX_W + 1;

  if (((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) || (MEM_LATENCY < 1)) begin : g_bad_cfg
    $error("mem_fill_arbiter: WORDS_PER_BLOCK must be a power of 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  state_t                  state;
  logic                    owner_d;
  logic [ADDR_W-1:OFF_W]   base_hi;
  logic [IDX_W:0]          issue_cnt;
  logic [IDX_W-1:0]        recv_cnt;
  logic                    mem_en_r;
  logic                    mem_wr_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic [DATA_W-1:0]       mem_wdata_r;
  logic                    ack_r;
  logic                    pick_d;
  logic                    rx;
  logic                    rx_last;
  logic [ADDR_W-1:0]       miss_addr;
  logic                    unused_low_bits;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  // On a tie the requester that did not get the previous fill wins.
  assign pick_d = bus.dcache_miss && (!bus.icache_miss || !last_d);
`else
  assign pick_d = bus.dcache_miss;
`endif

  assign miss_addr = pick_d ? bus.dcache_miss_addr : bus.icache_miss_addr;
  assign rx        = rst_n && (state == FILL) && bus.mem_data_valid;
  assign rx_last   = rx && (recv_cnt == IDX_W'(WORDS_PER_BLOCK - 1));

  assign unused_low_bits = ^{bus.icache_miss_addr[OFF_W-1:0], bus.dcache_miss_addr[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      base_hi     <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      ack_r       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d      <= 1'b0;
`endif
    end else begin
      mem_en_r <= 1'b0;
      mem_wr_r <= 1'b0;
      ack_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dcache_wr_req) begin
            state       <= WRITE;
            mem_en_r    <= 1'b1;
            mem_wr_r    <= 1'b1;
            mem_addr_r  <= bus.dcache_wr_addr;
            mem_wdata_r <= bus.dcache_wr_data;
            ack_r       <= 1'b1;
          end else if (bus.dcache_miss || bus.icache_miss) begin
            // First word address is issued straight from the grant edge.
            state      <= FILL;
            owner_d    <= pick_d;
            base_hi    <= miss_addr[ADDR_W-1:OFF_W];
            mem_en_r   <= 1'b1;
            mem_addr_r <= {miss_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            issue_cnt  <= (IDX_W+1)'(1);
            recv_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d     <= pick_d;
`endif
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          if (issue_cnt < (IDX_W+1)'(WORDS_PER_BLOCK)) begin
            mem_en_r   <= 1'b1;
            mem_addr_r <= {base_hi, issue_cnt[IDX_W-1:0], 1'b0};
            issue_cnt  <= issue_cnt + 1'b1;
          end
          if (rx) recv_cnt <= recv_cnt + 1'b1;
          if (rx_last) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en         = mem_en_r;
  assign bus.mem_wr         = mem_wr_r;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.mem_wdata      = mem_wdata_r;
  assign bus.dcache_wr_ack  = ack_r;
  assign bus.fill_data      = bus.mem_rdata;
  assign bus.fill_word_idx  = recv_cnt;
  assign bus.icache_fill_we = rx && !owner_d;
  assign bus.dcache_fill_we = rx && owner_d;
  assign bus.icache_tag_we  = rx_last && !owner_d;
  assign bus.dcache_tag_we  = rx_last && owner_d;
  assign bus.icache_busy    = (state == FILL) && !owner_d;
  assign bus.dcache_busy    = ((state == FILL) && owner_d) || (state == WRITE);
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: 4-cycle memory model, cache requesters that drop on tag_we/ack.
module tb_mem_fill_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16), .IDX_W(3)) bus();

  mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_at = -100;
  logic spur = 1'b0;
  bit hold = 1'b0;

  logic        pend_v [64];
  logic [15:0] pend_a [64];

  logic        lg_en [256], lg_wr [256], lg_ack [256], lg_ifw [256], lg_dfw [256];
  logic        lg_itag [256], lg_dtag [256], lg_ib [256], lg_db [256];
  logic [15:0] lg_addr [256], lg_wd [256], lg_fd [256];
  logic [2:0]  lg_idx [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive memory returns and requester drops after the edge, log outputs at negedge.
  task automatic tick();
    int p, l;
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == rst_at) rst_n = 1'b0;
    if (cyc == rst_at + 2) rst_n = 1'b1;
    p = cyc % 64;
    bus.mem_data_valid = pend_v[p] | spur;
    bus.mem_rdata = pend_v[p] ? (pend_a[p] ^ 16'h5A5A) : 16'h0000;
    pend_v[p] = 1'b0;
    l = (cyc - 1) % 256;
    if (!hold) begin
      if (lg_itag[l]) bus.icache_miss = 1'b0;
      if (lg_dtag[l]) bus.dcache_miss = 1'b0;
      if (lg_ack[l])  bus.dcache_wr_req = 1'b0;
    end
    @(negedge clk);
    l = cyc % 256;
    lg_en[l] = bus.mem_en;          lg_wr[l] = bus.mem_wr;
    lg_addr[l] = bus.mem_addr;      lg_wd[l] = bus.mem_wdata;
    lg_ack[l] = bus.dcache_wr_ack;  lg_fd[l] = bus.fill_data;
    lg_ifw[l] = bus.icache_fill_we; lg_dfw[l] = bus.dcache_fill_we;
    lg_itag[l] = bus.icache_tag_we; lg_dtag[l] = bus.dcache_tag_we;
    lg_ib[l] = bus.icache_busy;     lg_db[l] = bus.dcache_busy;
    lg_idx[l] = bus.fill_word_idx;
    if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
      pend_v[(cyc + 4) % 64] = 1'b1;
      pend_a[(cyc + 4) % 64] = bus.mem_addr;
    end
  endtask

  task automatic chk_zero(input string tag, input int c);
    int i;
    i = c % 256;
    chk({tag, ".en"}, lg_en[i], 0);      chk({tag, ".wr"}, lg_wr[i], 0);
    chk({tag, ".addr"}, lg_addr[i], 0);  chk({tag, ".wd"}, lg_wd[i], 0);
    chk({tag, ".ack"}, lg_ack[i], 0);    chk({tag, ".idx"}, lg_idx[i], 0);
    chk({tag, ".ifw"}, lg_ifw[i], 0);    chk({tag, ".dfw"}, lg_dfw[i], 0);
    chk({tag, ".itag"}, lg_itag[i], 0);  chk({tag, ".dtag"}, lg_dtag[i], 0);
    chk({tag, ".ib"}, lg_ib[i], 0);      chk({tag, ".db"}, lg_db[i], 0);
  endtask

  // Fill granted at the edge ending cycle c0: issues in c0+1..8, returns in c0+5..12, idle at c0+13.
  task automatic check_fill(input string tag, input int c0, input bit isd, input logic [15:0] base);
    int i;
    for (int k = 1; k <= 8; k++) begin
      i = (c0 + k) % 256;
      chk({tag, ".en"}, lg_en[i], 1);
      chk({tag, ".wr"}, lg_wr[i], 0);
      chk({tag, ".addr"}, lg_addr[i], base + 16'(2 * (k - 1)));
    end
    chk({tag, ".en9"}, lg_en[(c0 + 9) % 256], 0);
    for (int k = 4; k <= 12; k++) begin
      i = (c0 + k) % 256;
      chk({tag, ".fwe"}, isd ? lg_dfw[i] : lg_ifw[i], (k >= 5) ? 1 : 0);
      chk({tag, ".ofwe"}, isd ? lg_ifw[i] : lg_dfw[i], 0);
      chk({tag, ".tag"}, isd ? lg_dtag[i] : lg_itag[i], (k == 12) ? 1 : 0);
      if (k >= 5) begin
        chk({tag, ".idx"}, lg_idx[i], k - 5);
        chk({tag, ".data"}, lg_fd[i], (base + 16'(2 * (k - 5))) ^ 16'h5A5A);
      end
    end
    chk({tag, ".busy12"}, isd ? lg_db[(c0 + 12) % 256] : lg_ib[(c0 + 12) % 256], 1);
    chk({tag, ".busy13"}, isd ? lg_db[(c0 + 13) % 256] : lg_ib[(c0 + 13) % 256], 0);
  endtask

  initial begin
    int c0;
    logic exp_d [4];
    for (int i = 0; i < 64; i++) pend_v[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      lg_itag[i] = 1'b0; lg_dtag[i] = 1'b0; lg_ack[i] = 1'b0;
    end
    bus.icache_miss = 1'b0; bus.icache_miss_addr = '0;
    bus.dcache_miss = 1'b0; bus.dcache_miss_addr = '0;
    bus.dcache_wr_req = 1'b0; bus.dcache_wr_addr = '0; bus.dcache_wr_data = '0;
    bus.mem_rdata = '0; bus.mem_data_valid = 1'b0;

    // Power-on reset
    tick(); tick();
    chk_zero("rst", cyc);
    rst_n = 1'b1;
    tick();

    // Single I-cache fill
    c0 = cyc;
    bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h1236;
    repeat (16) tick();
    check_fill("i1", c0, 1'b0, 16'h1230);

    // Simultaneous misses: D first, I starts 13 cycles later
    c0 = cyc;
    bus.dcache_miss = 1'b1; bus.dcache_miss_addr = 16'h2008;
    bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h3456;
    repeat (30) tick();
    check_fill("d2", c0, 1'b1, 16'h2000);
    check_fill("i2", c0 + 13, 1'b0, 16'h3450);
    for (int k = 1; k <= 13; k++) chk("i2.nobusy", lg_ib[(c0 + k) % 256], 0);

    // Store and D miss arriving during an I fill wait, store goes first
    c0 = cyc;
    bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h4010;
    repeat (3) tick();
    bus.dcache_wr_req = 1'b1; bus.dcache_wr_addr = 16'h0040; bus.dcache_wr_data = 16'hBEEF;
    bus.dcache_miss = 1'b1; bus.dcache_miss_addr = 16'h5000;
    repeat (30) tick();
    check_fill("i3", c0, 1'b0, 16'h4010);
    for (int k = 1; k <= 13; k++) chk("w3.noack", lg_ack[(c0 + k) % 256], 0);
    chk("w3.en", lg_en[(c0 + 14) % 256], 1);
    chk("w3.wr", lg_wr[(c0 + 14) % 256], 1);
    chk("w3.addr", lg_addr[(c0 + 14) % 256], 16'h0040);
    chk("w3.wd", lg_wd[(c0 + 14) % 256], 16'hBEEF);
    chk("w3.ack", lg_ack[(c0 + 14) % 256], 1);
    chk("w3.db", lg_db[(c0 + 14) % 256], 1);
    chk("w3.ack1", lg_ack[(c0 + 15) % 256], 0);
    chk("w3.en1", lg_en[(c0 + 15) % 256], 0);
    check_fill("d3", c0 + 15, 1'b1, 16'h5000);

    // Spurious valid in IDLE
    c0 = cyc;
    spur = 1'b1;
    tick(); tick();
    spur = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      chk("sp.ifw", lg_ifw[(c0 + k) % 256], 0);
      chk("sp.dfw", lg_dfw[(c0 + k) % 256], 0);
      chk("sp.itag", lg_itag[(c0 + k) % 256], 0);
    end

    // Reset during cycle 6 of an I fill, held 2 cycles
    c0 = cyc;
    bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h6000;
    rst_at = c0 + 6;
    repeat (6) tick();
    bus.icache_miss = 1'b0;
    repeat (10) tick();
    chk("rm.fw5", lg_ifw[(c0 + 5) % 256], 1);
    chk("rm.en6", lg_en[(c0 + 6) % 256], 1);
    chk_zero("rm", c0 + 7);
    for (int k = 6; k <= 16; k++) begin
      chk("rm.ifw", lg_ifw[(c0 + k) % 256], 0);
      chk("rm.itag", lg_itag[(c0 + k) % 256], 0);
    end
    c0 = cyc;
    bus.icache_miss = 1'b1;
    repeat (16) tick();
    check_fill("i4", c0, 1'b0, 16'h6000);

    // Both misses held continuously
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    c0 = cyc;
    hold = 1'b1;
    bus.dcache_miss = 1'b1; bus.dcache_miss_addr = 16'h7000;
    bus.icache_miss = 1'b1; bus.icache_miss_addr = 16'h8000;
    repeat (52) tick();
    hold = 1'b0;
    bus.dcache_miss = 1'b0; bus.icache_miss = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("hb.db", lg_db[(c0 + 1 + 13 * n) % 256], exp_d[n]);
      chk("hb.ib", lg_ib[(c0 + 1 + 13 * n) % 256], !exp_d[n]);
      chk("hb.addr", lg_addr[(c0 + 1 + 13 * n) % 256], exp_d[n] ? 16'h7000 : 16'h8000);
    end
    repeat (16) tick();
    chk("end.ib", lg_ib[cyc % 256], 0);
    chk("end.db", lg_db[cyc % 256], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
